vmask_expand: RTL
=================

Name: vmask_expand

Overview:
- Mask-register reader paired with the mask-compare unit.
- The compare unit packs per-element results into mask bits. This block unpacks a stored mask word back into per-byte write enables, one data beat at a time.
- Feeds masked vector writeback and lane operations: element i is enabled iff mask bit i is set and i < vl.
- Loads a mask and a command while idle, then steps a beat counter across the vector, honouring output backpressure.

Parameters:
- REQ_DATA_WIDTH, 64, data beat width in bits.
- REQ_BYTE_EN_WIDTH, REQ_DATA_WIDTH/8, byte enables per beat.
- REQ_ADDR_WIDTH, 32, beat address width.
- MASK_WIDTH, 64, mask bits held; maximum vl.
- VL_WIDTH, 7, vl field width; must hold MASK_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  command/mask offered
- in_ready  out  1  block idle, command accepted when in_valid & in_ready
- in_mask  in  MASK_WIDTH  mask word; bit i belongs to element i
- in_sew  in  3  element width: 0=8b, 1=16b, 2=32b, 3=64b; values 4-7 are treated as 3
- in_vl  in  VL_WIDTH  element count; values above MASK_WIDTH clamp to MASK_WIDTH
- in_addr  in  REQ_ADDR_WIDTH  address of beat 0
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_be  out  REQ_BYTE_EN_WIDTH  byte enables for the current beat
- out_addr  out  REQ_ADDR_WIDTH  in_addr + beat index
- out_last  out  1  final beat of the command

Behaviour:
- Reset (asynchronous, any state, including mid-command):
  - state = IDLE, in_ready = 1.
  - out_valid, out_be, out_addr, out_last and all internal registers = 0.
  - A partially emitted command is dropped.
- States:
  - IDLE: in_ready = 1. On handshake, latch mask, sew, clamped vl and addr; clear beat counter.
    - vl = 0: stay in IDLE, emit nothing.
    - Otherwise: go to RUN and present beat 0 in the next cycle, so first out_valid arrives 1 cycle after acceptance.
  - RUN: in_ready = 0; in_valid is ignored. Outputs are registered and held stable while out_valid & !out_ready.
    - On out_valid & out_ready with out_last = 0: present the next beat in the following cycle, giving 1 beat per cycle under continuous ready.
    - On out_valid & out_ready with out_last = 1: deassert out_valid and return to IDLE. in_ready rises the cycle after the last handshake.
- Beat arithmetic:
  - epb = REQ_BYTE_EN_WIDTH >> sew (elements per beat).
  - beats = ceil(vl / epb).
  - For beat b and slot k < epb: element e = b*epb + k.
  - Bytes [k*(1<<sew) +: (1<<sew)] of out_be = mask[e] & (e < vl).
  - Tail slots (e >= vl) are 0.
  - out_last = (b == beats-1).
  - out_addr = in_addr + b, wrapping modulo 2^REQ_ADDR_WIDTH.
- Boundary cases:
  - vl = MASK_WIDTH at sew = 0: 8 beats.
  - vl = 1 at sew = 3: 1 beat, out_last = 1 on the first beat.
  - An all-zero mask still emits every beat with out_be = 0, so the consumer sees the full address sequence.
  - out_ready may be held low indefinitely; nothing is lost or advanced.

Optional Feature:
- Macro: VMASK_EXPAND_INVERT_EN.
- Defined:
  - Adds input port in_inv (1 bit), latched with the command.
  - When latched as 1, the complement of in_mask is used. Tail elements (e >= vl) remain 0.
  - Serves merge/vm=0 "else" paths.
- Undefined:
  - Port is absent and the mask is used as given.
  - Behaviour is otherwise identical.

Test Plan:
- Single command, full rate: mask = 0x00000000000000A5, sew = 0, vl = 8, addr = 0x100, out_ready = 1.
  - Expect 1 beat 1 cycle after accept: out_be = 0xA5, out_addr = 0x100, out_last = 1.
  - Expect in_ready = 1 the following cycle.
- Wide elements, partial tail: mask = 0b1011, sew = 2, vl = 3, addr = 0x20.
  - Beat 0: out_be = 0xFF, addr 0x20.
  - Beat 1: out_be = 0x00 (element 3 beyond vl), addr 0x21, out_last = 1.
- Backpressure: mask = all ones, sew = 1, vl = 12, out_ready low for 3 cycles on beat 1.
  - Beat 1 held stable: out_be = 0xFFFF… low 8 bytes = 0xFF, addr +1.
  - 3 beats total, the last with out_be = 0xFF (elements 8-11 only), out_last = 1.
- vl = 0 and clamp:
  - vl = 0: no out_valid, in_ready stays 1.
  - vl = 100, sew = 0, mask = all ones: exactly 8 beats of out_be = 0xFF.
- Busy / reset:
  - in_valid asserted during RUN is not accepted; in_ready stays 0.
  - Asserting rst mid-command (beat 3 of 8) drives out_valid = 0 and in_ready = 1 immediately.
  - The next command restarts at beat 0.
- With VMASK_EXPAND_INVERT_EN: mask = 0x0F, in_inv = 1, sew = 0, vl = 6.
  - out_be = 0x30, out_last = 1.

Source files
------------

// File: rtl/vmask_expand.sv
// rtl/vmask_expand.sv - mask word to per-beat byte-enable expander (optional feature macro: VMASK_EXPAND_INVERT_EN adds in_inv)
module vmask_expand #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int REQ_ADDR_WIDTH    = 32,
    parameter int MASK_WIDTH        = 64,
    parameter int VL_WIDTH          = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MASK_WIDTH-1:0]        in_mask,
    input  logic [2:0]                   in_sew,
    input  logic [VL_WIDTH-1:0]          in_vl,
    input  logic [REQ_ADDR_WIDTH-1:0]    in_addr,
`ifdef VMASK_EXPAND_INVERT_EN
    input  logic                         in_inv,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
    output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
    output logic                         out_last
);

    localparam int MIDX_W = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [MASK_WIDTH-1:0]          mask_q, mask_d;
    logic [1:0]                     sew_q, sew_d;
    logic [VL_WIDTH-1:0]            vl_q, vl_d;
    logic [REQ_ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [VL_WIDTH-1:0]            beat_q, beat_d;
    logic                           out_valid_q, out_valid_d;
    logic [REQ_BYTE_EN_WIDTH-1:0]   out_be_q, out_be_d;
    logic [REQ_ADDR_WIDTH-1:0]      out_addr_q, out_addr_d;
    logic                           out_last_q, out_last_d;

    // Command fields as they will be latched: sew 4-7 behaves as 64b, vl clamps to MASK_WIDTH
    logic [MASK_WIDTH-1:0]          mask_in;
    logic [1:0]                     sew_in;
    logic [VL_WIDTH-1:0]            vl_in;
    logic [VL_WIDTH-1:0]            beat_nxt;

    assign sew_in   = in_sew[2] ? 2'd3 : in_sew[1:0];
    assign vl_in    = (in_vl > VL_WIDTH'(MASK_WIDTH)) ? VL_WIDTH'(MASK_WIDTH) : in_vl;
    assign beat_nxt = beat_q + VL_WIDTH'(1);

`ifdef VMASK_EXPAND_INVERT_EN
    // Inverted mask serves the "else" lane of merges; tail gating by vl still applies later
    assign mask_in = in_inv ? ~in_mask : in_mask;
`else
    assign mask_in = in_mask;
`endif

    // Expander operands: the incoming command for beat 0, otherwise the latched command for the next beat
    logic [MASK_WIDTH-1:0]          exp_mask;
    logic [1:0]                     exp_sew;
    logic [VL_WIDTH-1:0]            exp_vl;
    logic [VL_WIDTH-1:0]            exp_beat;
    logic [REQ_BYTE_EN_WIDTH-1:0]   exp_be;
    logic                           exp_last;
    int unsigned                    exp_epb;
    int unsigned                    exp_base;
    int unsigned                    exp_elem;

    // Pick which command the shared expander works on
    always_comb begin
        if (state_q == S_IDLE) begin
            exp_mask = mask_in;
            exp_sew  = sew_in;
            exp_vl   = vl_in;
            exp_beat = '0;
        end else begin
            exp_mask = mask_q;
            exp_sew  = sew_q;
            exp_vl   = vl_q;
            exp_beat = beat_nxt;
        end
    end

    // Byte j of a beat belongs to slot j>>sew; its element is beat*epb + slot, gated by vl
    always_comb begin
        exp_be   = '0;
        exp_epb  = 32'(REQ_BYTE_EN_WIDTH) >> exp_sew;
        exp_base = 32'(exp_beat) * exp_epb;
        exp_elem = '0;
        for (int j = 0; j < REQ_BYTE_EN_WIDTH; j++) begin
            exp_elem  = exp_base + (32'(j) >> exp_sew);
            exp_be[j] = (exp_elem < 32'(exp_vl)) & exp_mask[exp_elem[MIDX_W-1:0]];
        end
        exp_last = (exp_base + exp_epb) >= 32'(exp_vl);
    end

    // Next-state and handshake logic: accept in IDLE, step one beat per output handshake in RUN
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sew_d       = sew_q;
        vl_d        = vl_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_be_d    = out_be_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mask_d = mask_in;
                    sew_d  = sew_in;
                    vl_d   = vl_in;
                    addr_d = in_addr;
                    beat_d = '0;
                    if (vl_in != '0) begin
                        state_d     = S_RUN;
                        out_valid_d = 1'b1;
                        out_be_d    = exp_be;
                        out_addr_d  = in_addr;
                        out_last_d  = exp_last;
                    end
                end
            end
            S_RUN: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_be_d    = '0;
                        out_addr_d  = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        beat_d      = beat_nxt;
                        out_be_d    = exp_be;
                        out_addr_d  = addr_q + REQ_ADDR_WIDTH'(beat_nxt);
                        out_last_d  = exp_last;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partially emitted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            sew_q       <= '0;
            vl_q        <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_be_q    <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sew_q       <= sew_d;
            vl_q        <= vl_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_be_q    <= out_be_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_be    = out_be_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;

endmodule
